// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants, slot state encoding and helpers for the pipeline stage chain.
package pipe_stage_chain_pkg;

    // Default payload widths of the classic CPU pipeline boundaries.
    localparam int IF_ID_W = 64;
    localparam int ID_EX_W = 128;
    localparam int EX_DM_W = 96;
    localparam int DM_WB_W = 72;

    // Upper bound on chain length handled by the flush-mask helper.
    localparam int MaxStages = 32;

    // Fill level of one slot: empty, main register only, main plus skid.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_MAIN  = 2'd1,
        SLOT_BOTH  = 2'd2
    } slot_state_t;

    // Width needed to count every entry of a chain of 'stages' skid slots.
    function automatic int occWidth(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

    // A flush bit k kills stages 0..k, so stage i dies when any bit at or above i is set.
    function automatic logic [MaxStages-1:0] flushMask(input logic [MaxStages-1:0] flush);
        logic [MaxStages-1:0] mask;
        logic                 seen;
        mask = '0;
        seen = 1'b0;
        for (int k = MaxStages - 1; k >= 0; k--) begin
            seen    = seen | flush[k];
            mask[k] = seen;
        end
        return mask;
    endfunction

    // Number of valid entries represented by a slot state.
    function automatic logic [1:0] slotCount(input slot_state_t state);
        case (state)
            SLOT_MAIN: return 2'd1;
            SLOT_BOTH: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake, control and status bundle between a pipeline boundary and its neighbours.
interface pipe_stage_chain_if
    import pipe_stage_chain_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int Stages    = 1
) ();

    localparam int OccW = occWidth(Stages);

    logic                 en;
    logic [Stages-1:0]    flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [DataWidth-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DataWidth-1:0] out_data;
    logic [OccW-1:0]      occupancy;

    // Upstream stage and hazard unit side.
    modport master (
        output en, flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    // The chain itself.
    modport slave (
        input  en, flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/pipe_skid_slot.sv
// One chain slot: either a two-entry skid buffer with registered ready or a plain register.
module pipe_skid_slot
    import pipe_stage_chain_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter bit SkidEn    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_kill,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DataWidth-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DataWidth-1:0] o_data,
    output logic [1:0]           o_count
);

    slot_state_t          r_state;
    logic [DataWidth-1:0] r_main;
    logic                 w_push;
    logic                 w_pop;

    assign o_valid = (r_state != SLOT_EMPTY);
    assign o_data  = r_main;
    assign o_count = slotCount(r_state);
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    if (SkidEn) begin : g_skid
        logic [DataWidth-1:0] r_skid;

        // Ready depends only on the state register, so no ready path crosses slots.
        assign o_ready = (r_state != SLOT_BOTH);

        // Main drains first; an item arriving while main is stuck parks in skid.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= SLOT_EMPTY;
                r_main  <= '0;
                r_skid  <= '0;
            end else if (i_kill) begin
                r_state <= SLOT_EMPTY;
            end else if (i_en) begin
                case (r_state)
                    SLOT_EMPTY: begin
                        if (w_push) begin
                            r_main  <= i_data;
                            r_state <= SLOT_MAIN;
                        end
                    end
                    SLOT_MAIN: begin
                        if (w_push && w_pop) begin
                            r_main <= i_data;
                        end else if (w_push) begin
                            r_skid  <= i_data;
                            r_state <= SLOT_BOTH;
                        end else if (w_pop) begin
                            r_state <= SLOT_EMPTY;
                        end
                    end
                    SLOT_BOTH: begin
                        if (w_pop) begin
                            r_main  <= r_skid;
                            r_state <= SLOT_MAIN;
                        end
                    end
                    default: r_state <= SLOT_EMPTY;
                endcase
            end
        end
    end else begin : g_plain
        // A full slot can still accept when its own item leaves in the same cycle.
        assign o_ready = (r_state == SLOT_EMPTY) | i_ready;

        // Single register: load on accept, otherwise empty out on hand-off.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= SLOT_EMPTY;
                r_main  <= '0;
            end else if (i_kill) begin
                r_state <= SLOT_EMPTY;
            end else if (i_en) begin
                if (w_push) begin
                    r_main  <= i_data;
                    r_state <= SLOT_MAIN;
                end else if (w_pop) begin
                    r_state <= SLOT_EMPTY;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised inter-stage register chain with handshake, stall, per-stage flush and enable.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int Stages    = 1,
    parameter bit SkidEn    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stage_chain_if.slave bus
);

    localparam int OccW = occWidth(Stages);

    logic [MaxStages-1:0] w_flushWide;
    logic [MaxStages-1:0] w_killMask;
    logic [Stages-1:0]    w_kill;
    logic                 w_anyFlush;
    logic [Stages-1:0]    w_slotValid;
    logic [Stages-1:0]    w_slotReady;
    logic [DataWidth-1:0] w_slotData  [Stages];
    logic [1:0]           w_slotCount [Stages];
    logic [OccW-1:0]      w_occupancy;

    // Widen the flush vector so the shared mask helper can work on it.
    always_comb begin
        w_flushWide               = '0;
        w_flushWide[Stages-1:0]   = bus.flush;
    end

    assign w_killMask = flushMask(w_flushWide);
    assign w_kill     = w_killMask[Stages-1:0];
    assign w_anyFlush = |bus.flush;

    for (genvar k = 0; k < Stages; k++) begin : g_slot
        logic                 w_inValid;
        logic [DataWidth-1:0] w_inData;
        logic                 w_dnReady;

        if (k == 0) begin : g_head
            assign w_inValid = bus.in_valid & bus.en & ~w_anyFlush;
            assign w_inData  = bus.in_data;
        end else begin : g_body
            assign w_inValid = w_slotValid[k-1] & ~w_kill[k-1];
            assign w_inData  = w_slotData[k-1];
        end

        if (k == Stages - 1) begin : g_tail
            assign w_dnReady = bus.out_ready;
        end else begin : g_inner
            assign w_dnReady = w_slotReady[k+1];
        end

        pipe_skid_slot #(
            .DataWidth (DataWidth),
            .SkidEn    (SkidEn)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_en    (bus.en),
            .i_kill  (w_kill[k]),
            .i_valid (w_inValid),
            .o_ready (w_slotReady[k]),
            .i_data  (w_inData),
            .o_valid (w_slotValid[k]),
            .i_ready (w_dnReady),
            .o_data  (w_slotData[k]),
            .o_count (w_slotCount[k])
        );
    end

    // Occupancy follows the slot state registers, so it moves on the same edge as the data.
    always_comb begin
        w_occupancy = '0;
        for (int k = 0; k < Stages; k++) begin
            w_occupancy = w_occupancy + OccW'(w_slotCount[k]);
        end
    end

    assign bus.in_ready  = w_slotReady[0] & bus.en & ~w_anyFlush;
    assign bus.out_valid = w_slotValid[Stages-1] & bus.en & ~w_kill[Stages-1];
    assign bus.out_data  = w_slotData[Stages-1];
    assign bus.occupancy = w_occupancy;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a 3-stage skid chain and a 3-stage plain chain.
module tb_pipe_stage_chain;

    localparam int DataW     = 32;
    localparam int NumStages = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        tbEn;
    logic [2:0]  tbFlush;
    logic        tbInValid;
    logic [31:0] tbInData;
    logic        tbOutReady;
    logic        sel;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] feedVals [3];

    logic        obsInReady;
    logic        obsOutValid;
    logic [31:0] obsOutData;
    logic [2:0]  obsOcc;

    pipe_stage_chain_if #(.DataWidth(DataW), .Stages(NumStages)) sIf ();
    pipe_stage_chain_if #(.DataWidth(DataW), .Stages(NumStages)) pIf ();

    assign sIf.en        = tbEn;
    assign sIf.flush     = tbFlush;
    assign sIf.in_valid  = tbInValid;
    assign sIf.in_data   = tbInData;
    assign sIf.out_ready = tbOutReady;
    assign pIf.en        = tbEn;
    assign pIf.flush     = tbFlush;
    assign pIf.in_valid  = tbInValid;
    assign pIf.in_data   = tbInData;
    assign pIf.out_ready = tbOutReady;

    pipe_stage_chain #(.DataWidth(DataW), .Stages(NumStages), .SkidEn(1'b1)) uSkid (
        .clk (clk),
        .rst (rst),
        .bus (sIf)
    );

    pipe_stage_chain #(.DataWidth(DataW), .Stages(NumStages), .SkidEn(1'b0)) uPlain (
        .clk (clk),
        .rst (rst),
        .bus (pIf)
    );

    assign obsInReady  = sel ? pIf.in_ready  : sIf.in_ready;
    assign obsOutValid = sel ? pIf.out_valid : sIf.out_valid;
    assign obsOutData  = sel ? pIf.out_data  : sIf.out_data;
    assign obsOcc      = sel ? pIf.occupancy : sIf.occupancy;

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic outReady);
        tbInValid  = valid;
        tbInData   = data;
        tbOutReady = outReady;
    endtask

    task automatic resetChain();
        rst     = 1'b1;
        tbEn    = 1'b1;
        tbFlush = 3'b000;
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    // Streams nItems (the first 'preloaded' already inside) with out_ready=1 and checks order.
    task automatic streamItems(input logic [31:0] base, input int nItems, input int preloaded,
                               input int pauseAfter, input string tag);
        int sent;
        int recv;
        int cyc;
        int acceptCyc;
        int firstOutCyc;
        int paused;
        sent        = preloaded;
        recv        = 0;
        cyc         = 0;
        acceptCyc   = -1;
        firstOutCyc = -1;
        paused      = 0;
        tbOutReady  = 1'b1;
        while (recv < nItems && cyc < 80) begin
            tbEn      = !(recv == pauseAfter && paused < 3);
            tbInValid = (sent < nItems);
            tbInData  = base + 32'(sent);
            @(negedge clk);
            if (!tbEn) begin
                checkOutput({tag, "_pauseInReady"}, 32'(obsInReady), 32'd0);
                checkOutput({tag, "_pauseOutValid"}, 32'(obsOutValid), 32'd0);
                checkOutput({tag, "_pauseOcc"}, 32'(obsOcc), 32'd3);
                checkOutput({tag, "_pauseData"}, obsOutData, base + 32'(recv));
                paused++;
            end else begin
                if (tbInValid && obsInReady) begin
                    if (sent == preloaded) acceptCyc = cyc;
                    sent++;
                end
                if (obsOutValid) begin
                    checkOutput({tag, "_data"}, obsOutData, base + 32'(recv));
                    if (firstOutCyc < 0) firstOutCyc = cyc;
                    if (preloaded == 0 && recv + 3 <= nItems) begin
                        checkOutput({tag, "_occ"}, 32'(obsOcc), 32'd3);
                    end
                    recv++;
                end
            end
            tick();
            cyc++;
        end
        tbInValid = 1'b0;
        tbEn      = 1'b1;
        checkOutput({tag, "_count"}, 32'(recv), 32'(nItems));
        if (preloaded == 0) begin
            checkOutput({tag, "_latency"}, 32'(firstOutCyc - acceptCyc), 32'd3);
        end
    endtask

    // Pushes items with out_ready=0 until the chain refuses; returns at the refusing negedge.
    task automatic fillChain(input logic [31:0] base, input int cap, input string tag);
        int sent;
        sent       = 0;
        tbOutReady = 1'b0;
        tbEn       = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tbInValid = 1'b1;
            tbInData  = base + 32'(sent);
            @(negedge clk);
            if (!obsInReady) break;
            sent++;
            tick();
        end
        checkOutput({tag, "_fillCount"}, 32'(sent), 32'(cap));
        checkOutput({tag, "_fillOcc"}, 32'(obsOcc), 32'(cap));
        checkOutput({tag, "_fillInReady"}, 32'(obsInReady), 32'd0);
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        int seen;
        feedVals = '{32'hC, 32'hB, 32'hA};
        sel = 1'b0;
        resetChain();

        @(negedge clk);
        checkOutput("rst_occ", 32'(obsOcc), 32'd0);
        checkOutput("rst_outValid", 32'(obsOutValid), 32'd0);
        checkOutput("rst_outData", obsOutData, 32'd0);
        checkOutput("rst_inReady", 32'(obsInReady), 32'd1);
        checkOutput("rst_plainInReady", 32'(pIf.in_ready), 32'd1);
        checkOutput("rst_plainOcc", 32'(pIf.occupancy), 32'd0);
        tick();

        streamItems(32'h1, 8, 0, -1, "s1");
        @(negedge clk);
        checkOutput("s1_drainedOcc", 32'(obsOcc), 32'd0);
        tick();

        fillChain(32'h11, 6, "s2");
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checkOutput("s2_holdInReady", 32'(obsInReady), 32'd0);
            checkOutput("s2_holdOcc", 32'(obsOcc), 32'd6);
            checkOutput("s2_holdOutValid", 32'(obsOutValid), 32'd1);
            checkOutput("s2_holdOutData", obsOutData, 32'h11);
        end
        tick();
        streamItems(32'h11, 8, 6, -1, "s2");

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, feedVals[i], 1'b0);
            tick();
        end
        applyStimulus(1'b1, 32'hD, 1'b0);
        tbFlush = 3'b010;
        @(negedge clk);
        checkOutput("f1_inReady", 32'(obsInReady), 32'd0);
        checkOutput("f1_occBefore", 32'(obsOcc), 32'd3);
        checkOutput("f1_outValid", 32'(obsOutValid), 32'd1);
        tick();
        tbFlush = 3'b000;
        applyStimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("f1_occAfter", 32'(obsOcc), 32'd1);
        checkOutput("f1_survivorValid", 32'(obsOutValid), 32'd1);
        checkOutput("f1_survivorData", obsOutData, 32'hC);
        tick();
        @(negedge clk);
        checkOutput("f1_emptyOcc", 32'(obsOcc), 32'd0);
        checkOutput("f1_emptyOutValid", 32'(obsOutValid), 32'd0);
        checkOutput("f1_holdData", obsOutData, 32'hC);
        tick();

        applyStimulus(1'b1, 32'h44, 1'b0);
        tick();
        tbInValid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (obsOutValid) begin
                seen = 1;
                break;
            end
            tick();
        end
        checkOutput("f2_reachedOutput", 32'(seen), 32'd1);
        tbOutReady = 1'b1;
        tbFlush    = 3'b100;
        #1;
        checkOutput("f2_outValid", 32'(obsOutValid), 32'd0);
        checkOutput("f2_inReady", 32'(obsInReady), 32'd0);
        tick();
        tbFlush = 3'b000;
        @(negedge clk);
        checkOutput("f2_occ", 32'(obsOcc), 32'd0);
        checkOutput("f2_outValidAfter", 32'(obsOutValid), 32'd0);
        checkOutput("f2_holdData", obsOutData, 32'h44);
        tick();

        streamItems(32'h51, 8, 0, 2, "s5");

        fillChain(32'h61, 6, "rs");
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        tbInValid = 1'b0;
        @(negedge clk);
        checkOutput("rs_occ", 32'(obsOcc), 32'd0);
        checkOutput("rs_outValid", 32'(obsOutValid), 32'd0);
        checkOutput("rs_outData", obsOutData, 32'd0);
        checkOutput("rs_inReady", 32'(obsInReady), 32'd1);
        tick();

        sel = 1'b1;
        resetChain();
        streamItems(32'h71, 8, 0, -1, "p1");
        fillChain(32'h81, 3, "p2");
        tbOutReady = 1'b1;
        #1;
        checkOutput("p2_combReadyHigh", 32'(obsInReady), 32'd1);
        tbOutReady = 1'b0;
        #1;
        checkOutput("p2_combReadyLow", 32'(obsInReady), 32'd0);
        checkOutput("p2_headData", obsOutData, 32'h81);
        tick();
        streamItems(32'h81, 8, 3, -1, "p2");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
